// File: rtl/demux_tdm_sequencer.sv
// ---------------------------------------------------------------------------
// demux_tdm_sequencer
//
// Time-division sequencer placed directly upstream of a 1-to-4 demultiplexer.
// Items arrive from a producer over an active-low dav_ / active-high rfd
// handshake. The registered index p = {b1,b0} steers the current item to
// demultiplexer output p. A shadow copy of the frame being assembled is kept
// in s[3:0], and it is transferred to z3..z0 in one step when the fourth item
// completes its handshake. Downstream logic therefore never sees a partial
// frame.
//
// Parameters:
//   W         width of the data item x and of each z output
//
// Ports:
//   clock     system clock; all state changes on the rising edge
//   reset_    synchronous active-low reset; has priority over every input
//   x         data item, valid while dav_ = 0
//   dav_      data-available from producer, active low
//   rfd       ready-for-data to producer, active high
//   restart   synchronous frame restart (WAIT only); discards a partial frame
//   b1, b0    demultiplexer command variables, {b1,b0} = p
//   z3..z0    last completed frame; zk holds the item received at index k
//   frame_ok  one-cycle pulse on the cycle z3..z0 present a new frame
// ---------------------------------------------------------------------------
module demux_tdm_sequencer #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [W-1:0] x,
  input  logic         dav_,
  output logic         rfd,
  input  logic         restart,
  output logic         b1,
  output logic         b0,
  output logic [W-1:0] z3,
  output logic [W-1:0] z2,
  output logic [W-1:0] z1,
  output logic [W-1:0] z0,
  output logic         frame_ok
);

  // WAIT: ready for an item (rfd = 1). ACK: item taken, waiting for dav_ = 1.
  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  state_e       state_q,    state_d;
  logic [1:0]   p_q,        p_d;
  logic         rfd_q,      rfd_d;
  logic         frame_ok_q, frame_ok_d;
  logic [W-1:0] s_q [4];
  logic [W-1:0] s_d [4];
  logic [W-1:0] z_q [4];
  logic [W-1:0] z_d [4];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold/default value before the case so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    p_d        = p_q;
    rfd_d      = rfd_q;
    s_d        = s_q;
    z_d        = z_q;
    frame_ok_d = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (restart) begin
          // restart wins over a simultaneous dav_ = 0: the item is not taken
          // and the producer keeps waiting for rfd to drop.
          p_d = '0;
          for (int k = 0; k < 4; k++) s_d[k] = '0;
        end else if (!dav_) begin
          s_d[p_q] = x;
          rfd_d    = 1'b0;
          state_d  = ST_ACK;
        end
      end

      ST_ACK: begin
        // restart is deliberately ignored here; only dav_ returning high
        // closes the handshake, so one held-low dav_ yields one item.
        if (dav_) begin
          rfd_d   = 1'b1;
          state_d = ST_WAIT;
          if (p_q == 2'd3) begin
            // s_q[3] already holds the item captured on entry to ACK, so the
            // whole frame is complete and can be published at once.
            p_d        = '0;
            z_d        = s_q;
            frame_ok_d = 1'b1;
          end else begin
            p_d = p_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = ST_WAIT;
        rfd_d   = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of its neighbours regardless of statement order.
    if (!reset_) begin
      state_q    <= ST_WAIT;
      p_q        <= '0;
      rfd_q      <= 1'b1;
      frame_ok_q <= 1'b0;
      // NOTE: the shadow and output frame registers are reset explicitly; the
      // outputs must read zero after reset and a partial frame must never
      // leak stale data, so these are real flops, not RAM.
      for (int k = 0; k < 4; k++) begin
        s_q[k] <= '0;
        z_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      rfd_q      <= rfd_d;
      frame_ok_q <= frame_ok_d;
      s_q        <= s_d;
      z_q        <= z_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all driven straight from registers
  // -------------------------------------------------------------------------
  assign rfd      = rfd_q;
  assign b1       = p_q[1];
  assign b0       = p_q[0];
  assign z3       = z_q[3];
  assign z2       = z_q[2];
  assign z1       = z_q[1];
  assign z0       = z_q[0];
  assign frame_ok = frame_ok_q;

endmodule

// File: doc/demux_tdm_sequencer.md
Name: demux_tdm_sequencer

Overview:
- Time-division sequencer sitting directly upstream of the 1-to-4 demultiplexer.
- Accepts a stream of W-bit items from a producer over a dav_/rfd handshake and generates the command variables b1,b0 that steer the current item to output p.
- Also keeps a double-buffered copy of a complete 4-item frame. Outputs z3..z0 update all at once only when a frame completes, so downstream logic never sees a partial frame.

Parameters:
- W, 1, width of the data item x and of each z output.

Ports:
- clock  input  1  single system clock; all state changes on posedge.
- reset_  input  1  synchronous, active-low reset, sampled on posedge clock.
- x  input  W  data item from producer; valid while dav_=0.
- dav_  input  1  data-available, active-low, driven by producer.
- rfd  output  1  ready-for-data, active-high, to producer.
- restart  input  1  synchronous frame restart; discards a partial frame.
- b1  output  1  command variable MSB (p[1]) to demultiplexer.
- b0  output  1  command variable LSB (p[0]) to demultiplexer.
- z3,z2,z1,z0  output  W each  registered frame outputs; zk holds the item received at index k of the last completed frame.
- frame_ok  output  1  one-cycle pulse when z3..z0 are loaded with a new frame.

Behaviour:
- Internal state:
  - 2-bit index p; {b1,b0} = p, registered, never combinational from inputs.
  - Four W-bit shadow registers s3..s0.
  - FSM with states WAIT and ACK.
- Reset (reset_=0 at posedge): state=WAIT, p=0, rfd=1, s3..s0=0, z3..z0=0, frame_ok=0. Reset has priority over every other input.
- WAIT (rfd=1):
  - restart=1: p<=0, s3..s0<=0, stay WAIT. restart has priority over dav_=0 in the same cycle; that item is not captured and the producer keeps waiting.
  - else if dav_=0: s[p]<=x, rfd<=0, go ACK.
  - else: hold.
- ACK (rfd=0):
  - restart is ignored.
  - Wait for dav_=1. On the posedge sampling dav_=1: rfd<=1, go WAIT, and:
    - if p!=3: p<=p+1.
    - if p==3: p<=0 (wrap), z3..z0<=s3..s0 in the same edge (s3 includes the item just captured), frame_ok<=1 for exactly one cycle.
- frame_ok is 0 in every other cycle.
- Latency:
  - rfd falls 1 cycle after the edge at which dav_=0 is sampled.
  - rfd rises, and {b1,b0} advances, 1 cycle after dav_=1 is sampled in ACK.
  - z and frame_ok change on that same edge.
- Minimum item period: 2 cycles (dav_ low for 1 sampled edge, high for 1 sampled edge).
- z3..z0 hold their value across partial frames, restart, and idle periods. They change only on frame completion or reset.
- dav_ held low across several WAIT->ACK cycles: exactly one item is captured per handshake. A new item is accepted only after dav_ has returned high.
- Reset mid-handshake (state ACK): block returns to WAIT with rfd=1. The producer must treat the pending item as lost.
- x is sampled only on the edge that leaves WAIT; x changes at other times are ignored.

Test Plan:
- Reset check, W=4: assert reset_=0 for 2 cycles, then release -> rfd=1, {b1,b0}=00, z3..z0=0, frame_ok=0.
- Full frame, W=4: send items 4'hA, 4'h5, 4'hC, 4'h3 with a 2-cycle handshake each -> {b1,b0} steps 00,01,10,11 then 00; on the edge after the 4th dav_ release, z0=A, z1=5, z2=C, z3=3 and frame_ok=1 for exactly 1 cycle.
- Partial frame then restart: send 4'h1, 4'h2, then pulse restart in WAIT -> {b1,b0}=00, z unchanged from the previous frame; next 4 items 4'h7,8,9,E -> z0..z3=7,8,9,E.
- Simultaneous restart and dav_=0 in WAIT -> no capture, rfd stays 1, p=0; the held dav_=0 is captured on the following cycle into s0.
- Handshake stretch: hold dav_=0 for 5 cycles, then high for 3 cycles -> rfd low from cycle 2 until 1 cycle after dav_ rises; p increments exactly once; x changes during ACK have no effect on the stored item.
- Reset during ACK after 3 items -> rfd=1, p=0, z=0, frame_ok never pulses.
